// File: rtl/hsv_core_pkg.sv
// Shared types and helpers for the hsv_core ALU front end.
package hsv_core_pkg;

    typedef enum logic [1:0] {
        ALU_BITWISE_AND  = 2'd0,
        ALU_BITWISE_OR   = 2'd1,
        ALU_BITWISE_XOR  = 2'd2,
        ALU_BITWISE_PASS = 2'd3
    } alu_bitwise_t;

    // Sign-extends a 32-bit word to the widest supported XLEN; callers use the low XLEN bits.
    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/hsv_core_skid_buffer.sv
// Two-entry valid/ready register slice: one output register plus one skid register.
module hsv_core_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         vld_p1;
    logic         skid_vld;
    logic [W-1:0] data_p1;
    logic [W-1:0] skid_p1;
    logic         accept;

    // ready depends only on the skid flop, so upstream never sees a combinational path.
    assign in_ready  = ~skid_vld;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
            data_p1  <= '0;
            skid_p1  <= '0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!vld_p1 || out_ready) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_vld) begin
                data_p1  <= skid_p1;
                vld_p1   <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                vld_p1 <= accept;
                if (accept) begin
                    data_p1 <= in_data;
                end
            end
        end else if (accept) begin
            skid_p1  <= in_data;
            skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/hsv_core_alu_operand_setup.sv
// ALU setup stage: builds funnel-shift operands, shift count and compare-ready
// adder operands, then registers them through a two-entry skid buffer.
module hsv_core_alu_operand_setup
    import hsv_core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                    clk_core,
    input  logic                    rst_core_n,
    input  logic                    flush_req,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [XLEN-1:0]         in_rs1,
    input  logic [XLEN-1:0]         in_rs2,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    in_is_immediate,
    input  logic                    in_negate,
    input  logic                    in_flip_signs,
    input  logic                    in_sign_extend,
    input  logic                    in_pc_relative,
    input  logic                    in_word_op,
    input  alu_bitwise_t            in_bitwise_select,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [XLEN-1:0]         out_shift_lo,
    output logic [XLEN-1:0]         out_shift_hi,
    output logic [$clog2(XLEN)-1:0] out_shift_count,
    output logic [XLEN:0]           out_adder_a,
    output logic [XLEN:0]           out_adder_b,
    output logic                    out_word_op,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int SHW = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0]  lo;
        logic [XLEN-1:0]  hi;
        logic [SHW-1:0]   cnt;
        logic [XLEN:0]    adder_a;
        logic [XLEN:0]    adder_b;
        logic             word;
        logic [TAG_W-1:0] tag;
    } payload_t;

    payload_t pl_p0;
    payload_t pl_p1;

    logic                   word;
    logic [XLEN-1:0]        b_raw;
    logic [XLEN-1:0]        rs1_sx;
    logic [XLEN-1:0]        rs1_zx;
    logic [XLEN-1:0]        b_sx;
    logic [XLEN-1:0]        a_op;
    logic [XLEN-1:0]        b_op;
    logic [SHW-1:0]         n;
    logic                   shift_left;
    logic                   fill;
    logic signed [XLEN:0]   a_ext;
    logic signed [XLEN:0]   b_ext;
    logic signed [XLEN:0]   b_neg;

    assign word  = (XLEN == 64) && in_word_op;
    assign b_raw = in_is_immediate ? in_imm : in_rs2;

    if (XLEN == 64) begin : g_rv64
        assign rs1_sx = sext32(in_rs1[31:0]);
        assign rs1_zx = {32'b0, in_rs1[31:0]};
        assign b_sx   = sext32(b_raw[31:0]);
    end else begin : g_rv32
        assign rs1_sx = in_rs1;
        assign rs1_zx = in_rs1;
        assign b_sx   = b_raw;
    end

    assign a_op = word ? rs1_sx : in_rs1;
    assign b_op = word ? b_sx : b_raw;
    assign n    = word ? SHW'(b_raw[4:0]) : b_raw[SHW-1:0];

    // A left shift by zero is issued as a right shift by zero so count never wraps to XLEN.
    assign shift_left = in_negate && (n != '0) && (in_bitwise_select == ALU_BITWISE_PASS);
    assign fill       = in_sign_extend & (word ? in_rs1[31] : a_op[XLEN-1]);

    always_comb begin
        pl_p0.lo  = '0;
        pl_p0.hi  = '0;
        pl_p0.cnt = '0;
        case (in_bitwise_select)
            ALU_BITWISE_AND: pl_p0.lo = a_op & b_raw;
            ALU_BITWISE_OR:  pl_p0.lo = a_op | b_raw;
            ALU_BITWISE_XOR: pl_p0.lo = a_op ^ b_raw;
            ALU_BITWISE_PASS: begin
                if (shift_left) begin
                    pl_p0.hi  = a_op;
                    pl_p0.cnt = '0 - n;
                end else begin
                    pl_p0.lo  = word ? (in_sign_extend ? rs1_sx : rs1_zx) : a_op;
                    pl_p0.hi  = {XLEN{fill}};
                    pl_p0.cnt = n;
                end
            end
        endcase
    end

    assign a_ext = {a_op[XLEN-1], a_op};
    assign b_ext = {b_op[XLEN-1], b_op};
    assign b_neg = in_negate ? -b_ext : b_ext;

    // The extra MSB turns the adder carry-out into a signed or unsigned less-than.
    always_comb begin
        if (in_flip_signs) begin
            pl_p0.adder_a = {~a_ext[XLEN], a_ext[XLEN-1:0]};
            pl_p0.adder_b = {~b_neg[XLEN], b_neg[XLEN-1:0]};
        end else begin
            pl_p0.adder_a = {1'b0, a_ext[XLEN-1:0]};
            pl_p0.adder_b = {(b_op != '0), b_neg[XLEN-1:0]};
        end
        if (in_pc_relative) begin
            pl_p0.adder_a = {1'b0, in_pc};
        end
    end

    assign pl_p0.word = word;
    assign pl_p0.tag  = in_tag;

    // ---- p0 -> p1: registered handoff to the shift/adder stage ----
    hsv_core_skid_buffer #(
        .W($bits(payload_t))
    ) u_skid (
        .clk       (clk_core),
        .rst_n     (rst_core_n),
        .flush     (flush_req),
        .in_valid  (valid_i),
        .in_ready  (ready_o),
        .in_data   (pl_p0),
        .out_valid (valid_o),
        .out_ready (ready_i),
        .out_data  (pl_p1)
    );

    assign out_shift_lo    = pl_p1.lo;
    assign out_shift_hi    = pl_p1.hi;
    assign out_shift_count = pl_p1.cnt;
    assign out_adder_a     = pl_p1.adder_a;
    assign out_adder_b     = pl_p1.adder_b;
    assign out_word_op     = pl_p1.word;
    assign out_tag         = pl_p1.tag;

endmodule

// File: tb/tb_hsv_core_alu_operand_setup.sv
// Directed bench for the ALU setup stage: XLEN=32 and XLEN=64 instances side by side.
module tb_hsv_core_alu_operand_setup;
    import hsv_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, flush, valid_i, ready_i;
    logic [63:0]  rs1, rs2, imm, pc;
    logic         is_imm, neg, flip, sext, pcrel, word;
    alu_bitwise_t sel;
    logic [7:0]   tag;

    logic         v32, r32, wo32;
    logic [31:0]  lo32, hi32;
    logic [4:0]   cnt32;
    logic [32:0]  aa32, ab32;
    logic [7:0]   tag32;

    logic         v64, r64, wo64;
    logic [63:0]  lo64, hi64;
    logic [5:0]   cnt64;
    logic [64:0]  aa64, ab64;
    logic [7:0]   tag64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hsv_core_alu_operand_setup #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush),
        .valid_i(valid_i), .ready_o(r32),
        .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_imm(imm[31:0]), .in_pc(pc[31:0]),
        .in_is_immediate(is_imm), .in_negate(neg), .in_flip_signs(flip),
        .in_sign_extend(sext), .in_pc_relative(pcrel), .in_word_op(word),
        .in_bitwise_select(sel), .in_tag(tag),
        .valid_o(v32), .ready_i(ready_i),
        .out_shift_lo(lo32), .out_shift_hi(hi32), .out_shift_count(cnt32),
        .out_adder_a(aa32), .out_adder_b(ab32), .out_word_op(wo32), .out_tag(tag32)
    );

    hsv_core_alu_operand_setup #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush),
        .valid_i(valid_i), .ready_o(r64),
        .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_pc(pc),
        .in_is_immediate(is_imm), .in_negate(neg), .in_flip_signs(flip),
        .in_sign_extend(sext), .in_pc_relative(pcrel), .in_word_op(word),
        .in_bitwise_select(sel), .in_tag(tag),
        .valid_o(v64), .ready_i(ready_i),
        .out_shift_lo(lo64), .out_shift_hi(hi64), .out_shift_count(cnt64),
        .out_adder_a(aa64), .out_adder_b(ab64), .out_word_op(wo64), .out_tag(tag64)
    );

    typedef struct {
        logic         x64;
        logic [63:0]  rs1, rs2, imm, pc;
        logic         is_imm, neg, flip, sext, pcrel, word;
        alu_bitwise_t sel;
        logic [63:0]  lo, hi;
        logic [6:0]   cnt;
        logic [64:0]  aa, ab;
        logic         wo;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(
        input logic x64, input logic [63:0] r1, input logic [63:0] r2,
        input logic [63:0] im, input logic [63:0] p,
        input logic ii, input logic ng, input logic fl, input logic se,
        input logic pr, input logic wd, input alu_bitwise_t s,
        input logic [63:0] elo, input logic [63:0] ehi, input logic [6:0] ecnt,
        input logic [64:0] eaa, input logic [64:0] eab, input logic ewo);
        vec_t v;
        v.x64 = x64; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.pc = p;
        v.is_imm = ii; v.neg = ng; v.flip = fl; v.sext = se; v.pcrel = pr; v.word = wd;
        v.sel = s; v.lo = elo; v.hi = ehi; v.cnt = ecnt; v.aa = eaa; v.ab = eab; v.wo = ewo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 64'hF0, 64'h4, 0, 0, 0, 1, 0, 0, 0, 0, ALU_BITWISE_PASS,
                      64'h0, 64'hF0, 7'd28, 65'h0_0000_00F0, 65'h1_FFFF_FFFC, 0);
        vecs[1]  = mk(0, 64'h8000_0001, 64'h55, 64'h0, 0, 1, 1, 0, 0, 0, 0, ALU_BITWISE_PASS,
                      64'h8000_0001, 64'h0, 7'd0, 65'h0_8000_0001, 65'h0, 0);
        vecs[2]  = mk(1, 64'h1234_5678_8000_0000, 64'h4, 0, 0, 0, 0, 0, 1, 0, 1, ALU_BITWISE_PASS,
                      64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 7'd4,
                      65'h0_FFFF_FFFF_8000_0000, 65'h1_0000_0000_0000_0004, 1);
        vecs[3]  = mk(0, 64'h1, 64'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0, ALU_BITWISE_XOR,
                      64'hFFFF_FFFE, 64'h0, 7'd0, 65'h0_0000_0001, 65'h1_0000_0001, 0);
        vecs[4]  = mk(0, 64'h1, 64'hFFFF_FFFF, 0, 0, 0, 1, 1, 0, 0, 0, ALU_BITWISE_AND,
                      64'h1, 64'h0, 7'd0, 65'h1_0000_0001, 65'h1_0000_0001, 0);
        vecs[5]  = mk(0, 64'hF0F0_0000, 64'h1234, 64'h0F0F, 0, 1, 0, 1, 0, 0, 0, ALU_BITWISE_OR,
                      64'hF0F0_0F0F, 64'h0, 7'd0, 65'h0_F0F0_0000, 65'h1_0000_0F0F, 0);
        vecs[6]  = mk(0, 64'hFFFF_0000, 64'h0, 64'h10, 64'h8000_1000, 1, 0, 0, 1, 1, 0, ALU_BITWISE_PASS,
                      64'hFFFF_0000, 64'hFFFF_FFFF, 7'd16, 65'h0_8000_1000, 65'h1_0000_0010, 0);
        vecs[7]  = mk(0, 64'h8000_0000, 64'h3, 0, 0, 0, 0, 0, 1, 0, 1, ALU_BITWISE_PASS,
                      64'h8000_0000, 64'hFFFF_FFFF, 7'd3, 65'h0_8000_0000, 65'h1_0000_0003, 0);
        vecs[8]  = mk(1, 64'h8000_0000_0000_0000, 64'h1_0000_0045, 0, 0, 0, 0, 0, 0, 0, 0, ALU_BITWISE_PASS,
                      64'h8000_0000_0000_0000, 64'h0, 7'd5,
                      65'h0_8000_0000_0000_0000, 65'h1_0000_0001_0000_0045, 0);
        vecs[9]  = mk(1, 64'h0000_0000_8000_0001, 64'h24, 0, 0, 0, 1, 0, 0, 0, 1, ALU_BITWISE_PASS,
                      64'h0, 64'hFFFF_FFFF_8000_0001, 7'd60,
                      65'h0_FFFF_FFFF_8000_0001, 65'h1_FFFF_FFFF_FFFF_FFDC, 1);
        vecs[10] = mk(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_FFFF_0000, 0, 0, 0, 0, 1, 0, 0, 0, ALU_BITWISE_XOR,
                      64'h5555_AAAA_5555_AAAA, 64'h0, 7'd0,
                      65'h0_AAAA_AAAA_AAAA_AAAA, 65'h0_FFFF_0000_FFFF_0000, 0);

        rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0; tag = '0;
        is_imm = 0; neg = 0; flip = 0; sext = 0; pcrel = 0; word = 0;
        sel = ALU_BITWISE_AND;
        tick();
        tick();
        chk("rst_valid32", v32, 0);
        chk("rst_ready32", r32, 1);
        chk("rst_lo32", lo32, 0);
        chk("rst_adder_b32", ab32, 0);
        chk("rst_valid64", v64, 0);
        chk("rst_ready64", r64, 1);
        chk("rst_hi64", hi64, 0);
        rst_n = 1'b1;
        ready_i = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            logic [63:0] glo, ghi;
            logic [6:0]  gcnt;
            logic [64:0] gaa, gab;
            logic        gv, gwo;
            logic [7:0]  gtag;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; imm = vecs[i].imm; pc = vecs[i].pc;
            is_imm = vecs[i].is_imm; neg = vecs[i].neg; flip = vecs[i].flip;
            sext = vecs[i].sext; pcrel = vecs[i].pcrel; word = vecs[i].word;
            sel = vecs[i].sel;
            tag = 8'(i + 1);
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            if (vecs[i].x64) begin
                glo = lo64; ghi = hi64; gcnt = {1'b0, cnt64};
                gaa = aa64; gab = ab64; gv = v64; gwo = wo64; gtag = tag64;
            end else begin
                glo = {32'b0, lo32}; ghi = {32'b0, hi32}; gcnt = {2'b0, cnt32};
                gaa = {32'b0, aa32}; gab = {32'b0, ab32}; gv = v32; gwo = wo32; gtag = tag32;
            end
            chk($sformatf("v%0d_valid", i), gv, 1);
            chk($sformatf("v%0d_shift_lo", i), glo, vecs[i].lo);
            chk($sformatf("v%0d_shift_hi", i), ghi, vecs[i].hi);
            chk($sformatf("v%0d_count", i), gcnt, vecs[i].cnt);
            chk($sformatf("v%0d_adder_a", i), gaa, vecs[i].aa);
            chk($sformatf("v%0d_adder_b", i), gab, vecs[i].ab);
            chk($sformatf("v%0d_word_op", i), gwo, vecs[i].wo);
            chk($sformatf("v%0d_tag", i), gtag, 8'(i + 1));
        end
        tick();
        chk("drain_valid32", v32, 0);

        // Backpressure: three stalled cycles, two beats held, released in order.
        rs1 = 64'h0; sel = ALU_BITWISE_AND; word = 0;
        ready_i = 1'b0; valid_i = 1'b1; tag = 8'h21;
        tick();
        chk("bp_a_tag", tag32, 8'h21);
        chk("bp_a_ready", r32, 1);
        tag = 8'h22;
        tick();
        chk("bp_b_ready", r32, 0);
        chk("bp_b_tag", tag32, 8'h21);
        tag = 8'h23;
        tick();
        chk("bp_c_valid", v32, 1);
        chk("bp_c_tag", tag32, 8'h21);
        chk("bp_c_ready", r32, 0);
        ready_i = 1'b1;
        tick();
        chk("bp_d_tag", tag32, 8'h22);
        chk("bp_d_valid", v32, 1);
        chk("bp_d_ready", r32, 1);
        tick();
        chk("bp_e_tag", tag32, 8'h23);
        valid_i = 1'b0;
        tick();
        chk("bp_f_valid", v32, 0);

        // Flush with both entries full and input still offered.
        ready_i = 1'b0; valid_i = 1'b1; tag = 8'h31;
        tick();
        tag = 8'h32;
        tick();
        chk("fl_full_ready", r32, 0);
        flush = 1'b1; tag = 8'h33;
        tick();
        chk("fl_valid", v32, 0);
        chk("fl_ready", r32, 1);
        tag = 8'h34;
        tick();
        chk("fl_accept_dropped", v32, 0);
        flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick();
        chk("fl_no_stale_1", v32, 0);
        tick();
        chk("fl_no_stale_2", v32, 0);

        // Reset in the middle of a stalled stream.
        ready_i = 1'b0; valid_i = 1'b1; tag = 8'h41; rs1 = 64'h1; rs2 = 64'hFFFF_FFFF;
        tick();
        tag = 8'h42;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr_valid", v32, 0);
        chk("mr_ready", r32, 1);
        chk("mr_tag", tag32, 0);
        chk("mr_lo", lo32, 0);
        chk("mr_adder_a", aa32, 0);
        rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        tick();
        chk("mr_no_stale", v32, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
